// File: rtl/data_mem_responder_if.sv
// Request/response channels between a data-memory requester and data_mem_responder.
// Optional req_be byte-enable lanes exist only when DATA_MEM_BYTE_EN is defined.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DATA_MEM_BYTE_EN
  logic [3:0]  req_be;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
`ifdef DATA_MEM_BYTE_EN
    output req_be,
`endif
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
`ifdef DATA_MEM_BYTE_EN
    input  req_be,
`endif
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering one load/store at a time after LATENCY wait cycles.
// Define DATA_MEM_BYTE_EN to add per-byte store enables (req_be).
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        live, lat, acc;
  logic        accept, acc_go, acc_err, ram_we;
  logic [29:0] acc_idx;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram_q;
  logic [31:0] ram [DEPTH];

  always_comb begin
    live.write = bus.req_write;
    live.addr  = bus.req_addr;
    live.wdata = bus.req_wdata;
`ifdef DATA_MEM_BYTE_EN
    live.be    = bus.req_be;
`else
    live.be    = 4'hF;
`endif
  end

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

  // Zero latency performs the access on the acceptance edge straight from the bus;
  // otherwise it happens on the edge the wait counter drains from 1 to 0.
  assign acc     = (state == IDLE) ? live : lat;
  assign acc_go  = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));
  assign acc_idx = acc.addr[31:2];
  assign acc_err = (acc.addr[1:0] != 2'b00) || ({2'b00, acc_idx} >= 32'(DEPTH));
  assign ram_idx = acc_idx[AW-1:0];
  assign ram_q   = ram[ram_idx];
  assign ram_we  = acc_go && acc.write && !acc_err && !reset;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (acc.be[i]) ram[ram_idx][8*i +: 8] <= acc.wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat            <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (acc_go) begin
        bus.resp_rdata <= (acc_err || acc.write) ? 32'h0 : ram_q;
        bus.resp_err   <= acc_err;
      end
      case (state)
        IDLE: if (accept) begin
          lat           <= live;
          cnt           <= 4'(LATENCY);
          bus.req_ready <= 1'b0;
          state         <= (LATENCY > 0) ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        // One edge inside RESP raises valid, giving LATENCY+1 edges from acceptance.
        RESP: begin
          if (!bus.resp_valid) bus.resp_valid <= 1'b1;
          else if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
